// File: rtl/seq_divider.sv
// seq_divider: iterative restoring shift-subtract divider, signed/unsigned, start/done handshake
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] div_q, div_d, quot_q, quot_d, prem_q, prem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d, done_q, done_d, dbz_q, dbz_d;
    logic [WIDTH:0] shifted, trial;
    logic [WIDTH-1:0] a_abs, b_abs;
    always_comb begin
        a_abs = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        b_abs = (signed_op && divisor[WIDTH-1]) ? -divisor : divisor;
        shifted = {prem_q, quot_q[WIDTH-1]};
        trial = shifted + ~{1'b0, div_q} + (WIDTH+1)'(1);
        state_d = state_q;
        div_d = div_q;
        quot_d = quot_q;
        prem_d = prem_q;
        cnt_d = cnt_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d = neg_rem_q;
        quotient_d = quotient_q;
        remainder_d = remainder_q;
        dbz_d = dbz_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && divisor == '0) begin
                    quotient_d = '1;
                    remainder_d = dividend;
                    dbz_d = 1'b1;
                    done_d = 1'b1;
                end else if (start) begin
                    div_d = b_abs;
                    quot_d = a_abs;
                    prem_d = '0;
                    cnt_d = '0;
                    neg_quot_d = signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = signed_op && dividend[WIDTH-1];
                    state_d = RUN;
                end
            end
            RUN: begin
                quot_d = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
                prem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                cnt_d = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WIDTH-1)) ? FIX : RUN;
            end
            FIX: begin
                quotient_d = neg_quot_q ? -quot_q : quot_q;
                remainder_d = neg_rem_q ? -prem_q : prem_q;
                dbz_d = 1'b0;
                done_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q <= '0;
            quot_q <= '0;
            prem_q <= '0;
            cnt_q <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quotient_q <= '0;
            remainder_q <= '0;
            dbz_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q <= div_d;
            quot_q <= quot_d;
            prem_q <= prem_d;
            cnt_q <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q <= neg_rem_d;
            quotient_q <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q <= dbz_d;
            done_q <= done_d;
        end
    end
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign quotient = quotient_q;
    assign remainder = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst, start, signed_op;
    logic [31:0] dividend, divisor, quotient, remainder;
    logic busy, done, div_by_zero;
    int errors = 0;
    int checks = 0;
    seq_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        dividend = a;
        divisor = b;
        signed_op = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic wait_done(output int n, output int bc);
        n = 0;
        bc = 0;
        while (!done && n < 100) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
    endtask
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input logic edbz, input int elat);
        int n, bc;
        launch(a, b, s);
        wait_done(n, bc);
        check({tag, " lat"}, n, elat);
        check({tag, " busycyc"}, bc, elat);
        check({tag, " done"}, {31'b0, done}, 32'd1);
        check({tag, " busy@done"}, {31'b0, busy}, 32'd0);
        check({tag, " q"}, quotient, eq);
        check({tag, " r"}, remainder, er);
        check({tag, " dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
        @(negedge clk);
        check({tag, " done1cyc"}, {31'b0, done}, 32'd0);
        check({tag, " qhold"}, quotient, eq);
    endtask
    initial begin
        int n, bc, dones;
        rst = 1'b1;
        start = 1'b0;
        signed_op = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst q", quotient, 32'd0);
        check("rst r", remainder, 32'd0);
        check("rst dbz", {31'b0, div_by_zero}, 32'd0);
        run("u100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
        run("s-100/7", 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33);
        run("u-100/7", 32'hFFFFFF9C, 32'd7, 1'b0, 32'h24924916, 32'd2, 1'b0, 33);
        run("s100/-7", 32'd100, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2, 1'b0, 33);
        run("u5/0", 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1, 0);
        run("s-5/0", 32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 0);
        run("smin/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 33);
        run("umax/1", 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 33);
        // start while busy must be ignored
        launch(32'd9, 32'd2, 1'b0);
        repeat (9) @(negedge clk);
        dividend = 32'd5;
        divisor = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bc);
        check("hs lat", n, 23);
        check("hs q", quotient, 32'd4);
        check("hs r", remainder, 32'd1);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("hs extra done", dones, 0);
        // back-to-back: start presented in the done cycle
        launch(32'd50, 32'd6, 1'b0);
        wait_done(n, bc);
        check("b2b first q", quotient, 32'd8);
        check("b2b first r", remainder, 32'd2);
        dividend = 32'd100;
        divisor = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy", {31'b0, busy}, 32'd1);
        wait_done(n, bc);
        check("b2b lat", n, 33);
        check("b2b q", quotient, 32'd14);
        check("b2b r", remainder, 32'd2);
        // reset at edge 15 of an operation
        launch(32'd1000, 32'd3, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst busy", {31'b0, busy}, 32'd0);
        check("mrst q", quotient, 32'd0);
        check("mrst r", remainder, 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("mrst no done", dones, 0);
        run("after rst 9/4", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, 33);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
